// File: rtl/pci_arbiter_if.sv
// PCI arbitration bus bundle: per-device REQ/GNT lines plus the shared FRAME/IRDY pair.
// The arbiter connects through the slave modport; devices or a bench use master.
interface pci_arbiter_if #(
  parameter int NUM_MASTERS = 3
);
  logic [NUM_MASTERS-1:0] REQ;
  logic [NUM_MASTERS-1:0] GNT;
  logic                   FRAME;
  logic                   IRDY;

  modport master (
    output REQ,
    output FRAME,
    output IRDY,
    input  GNT
  );

  modport slave (
    input  REQ,
    input  FRAME,
    input  IRDY,
    output GNT
  );
endinterface

// File: rtl/pci_arbiter.sv
// Central round-robin PCI arbiter: one grant at a time, an idle GNT gap between
// different owners, and withdrawal of grants that never see FRAME.
module pci_arbiter #(
  parameter int NUM_MASTERS   = 3,
  parameter int GRANT_TIMEOUT = 16,
  parameter int OWNER_W       = $clog2(NUM_MASTERS)
) (
  input  logic               clk,
  input  logic               rst,
  pci_arbiter_if.slave       bus,
  output logic [OWNER_W-1:0] owner,
  output logic               bus_busy,
  output logic               timeout_pulse
);

  localparam int TIMER_W = 5;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_GRANTED    = 3'd1;
  localparam logic [2:0] ST_BUSY       = 3'd2;
  localparam logic [2:0] ST_DRAIN      = 3'd3;
  localparam logic [2:0] ST_DRAIN_KEEP = 3'd4;

  localparam logic [NUM_MASTERS-1:0] ALL_ONES   = '1;
  localparam logic [NUM_MASTERS-1:0] ONE_HOT0   = NUM_MASTERS'(1);
  localparam logic [OWNER_W-1:0]     LAST_INIT  = OWNER_W'(NUM_MASTERS - 1);
  localparam logic [TIMER_W-1:0]     TIMER_LAST = TIMER_W'(GRANT_TIMEOUT - 1);

  logic [2:0]             state, state_nx;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_nx;
  logic [OWNER_W-1:0]     owner_nx;
  logic [OWNER_W-1:0]     last_owner, last_owner_nx;
  logic [TIMER_W-1:0]     timer, timer_nx;
  logic                   pulse_nx;

  logic                   bus_idle;
  logic                   any_req;
  logic                   owner_req;
  logic                   others_req;
  logic [OWNER_W-1:0]     sel;

  assign bus_idle   = bus.FRAME && bus.IRDY;
  assign any_req    = ~&bus.REQ;
  assign owner_req  = !bus.REQ[owner];
  assign others_req = |(~bus.REQ & ~(ONE_HOT0 << owner));

  // Walk candidates from farthest to nearest so the nearest requester after last_owner wins.
  always_comb begin
    int cand;
    sel = last_owner;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      cand = int'(last_owner) + k;
      if (cand >= NUM_MASTERS) begin
        cand = cand - NUM_MASTERS;
      end
      if (!bus.REQ[OWNER_W'(cand)]) begin
        sel = OWNER_W'(cand);
      end
    end
  end

  always_comb begin
    state_nx      = state;
    gnt_nx        = gnt_q;
    owner_nx      = owner;
    last_owner_nx = last_owner;
    timer_nx      = timer;
    pulse_nx      = 1'b0;

    case (state)
      ST_IDLE: begin
        gnt_nx = ALL_ONES;
        if (any_req && bus_idle) begin
          gnt_nx        = ~(ONE_HOT0 << sel);
          owner_nx      = sel;
          last_owner_nx = sel;
          timer_nx      = '0;
          state_nx      = ST_GRANTED;
        end
      end

      ST_GRANTED: begin
        if (!bus.FRAME) begin
          state_nx = ST_BUSY;
        end else if (!owner_req) begin
          gnt_nx   = ALL_ONES;
          state_nx = ST_IDLE;
        end else if (timer == TIMER_LAST) begin
          gnt_nx   = ALL_ONES;
          pulse_nx = 1'b1;
          state_nx = ST_IDLE;
        end else begin
          timer_nx = timer + TIMER_W'(1);
        end
      end

      // The grant is only re-evaluated once FRAME rises for the last data phase.
      ST_BUSY: begin
        if (bus.FRAME) begin
          if (owner_req && !others_req) begin
            state_nx = ST_DRAIN_KEEP;
          end else begin
            gnt_nx   = ALL_ONES;
            state_nx = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        gnt_nx = ALL_ONES;
        if (bus_idle) begin
          state_nx = ST_IDLE;
        end
      end

      ST_DRAIN_KEEP: begin
        if (bus_idle) begin
          timer_nx = '0;
          state_nx = ST_GRANTED;
        end
      end

      default: begin
        gnt_nx   = ALL_ONES;
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      gnt_q         <= ALL_ONES;
      owner         <= '0;
      last_owner    <= LAST_INIT;
      timer         <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      state         <= state_nx;
      gnt_q         <= gnt_nx;
      owner         <= owner_nx;
      last_owner    <= last_owner_nx;
      timer         <= timer_nx;
      timeout_pulse <= pulse_nx;
    end
  end

  assign bus.GNT  = gnt_q;
  assign bus_busy = (state == ST_BUSY);

  gnt_single: assert property (@(posedge clk) disable iff (rst) $onehot0(~gnt_q));

  gnt_gap: assert property (@(posedge clk) disable iff (rst)
    (gnt_q != ALL_ONES) |=> ((gnt_q == ALL_ONES) || $stable(gnt_q)));

endmodule

// File: doc/pci_arbiter.md
Name: pci_arbiter

Overview:
- Central PCI bus arbiter. It sits directly upstream of every PCI Device instance: it consumes each device's active-low REQ and drives that device's active-low GNT.
- It watches the shared FRAME and IRDY lines to track bus ownership. It grants fairly in round-robin order, inserts one all-idle GNT cycle between owners, and withdraws a grant whose master never starts a transaction.

Parameters:
- NUM_MASTERS, 3, number of requesting devices (legal range 2..8).
- GRANT_TIMEOUT, 16, cycles a granted master may leave FRAME high before its GNT is withdrawn (legal range 2..31).
- OWNER_W, $clog2(NUM_MASTERS), width of the owner index (derived; do not override).

Ports:
- clk  input  1  bus clock; all state updates on posedge.
- rst  input  1  asynchronous active-high reset.
- REQ  input  NUM_MASTERS  active-low request; bit i comes from device i.
- GNT  output  NUM_MASTERS  active-low grant; bit i goes to device i; registered.
- FRAME  input  1  shared bus FRAME, active-low.
- IRDY  input  1  shared bus IRDY, active-low.
- owner  output  OWNER_W  index of the current or last granted master.
- bus_busy  output  1  high while state is BUSY.
- timeout_pulse  output  1  one-cycle high pulse when a grant is withdrawn by timeout.

Behaviour:
- Reset (async assert, sync use after release):
  - GNT = all ones; owner = 0; bus_busy = 0; timeout_pulse = 0.
  - state = IDLE; last_owner = NUM_MASTERS-1, so master 0 wins the first round; timer = 0.
- Bus idle is defined as FRAME==1 && IRDY==1, sampled at posedge.
- Exactly one GNT bit may be low at any time. Every change of owner passes through at least one cycle with GNT all ones.
- Round-robin select: start at last_owner+1 (mod NUM_MASTERS) and take the first index with REQ low. Index arithmetic wraps modulo NUM_MASTERS, not modulo 2^OWNER_W.
- States:
  - IDLE:
    - Any REQ low at posedge, and bus idle -> GNT[sel] low from this edge; owner = last_owner = sel; timer = 0; go to GRANTED. Latency is REQ sampled low -> GNT low at the same edge's output, i.e. visible in the next cycle.
    - Bus not idle (a foreign or tail transaction) -> stay in IDLE, GNT all ones.
  - GRANTED:
    - FRAME sampled low -> BUSY; GNT[owner] stays low.
    - Else REQ[owner] sampled high (request withdrawn) -> GNT all ones, go to IDLE.
    - Else timer == GRANT_TIMEOUT-1 -> GNT all ones, timeout_pulse = 1 for one cycle, go to IDLE. last_owner already points at the timed-out master, so it gets lowest priority next round.
    - Otherwise timer increments by 1.
    - If FRAME low and REQ[owner] high occur together, FRAME wins (go to BUSY).
  - BUSY (bus_busy = 1):
    - GNT[owner] stays low until the first posedge with FRAME==1 (last data phase signalled).
    - At that edge: if another master has REQ low, GNT all ones and go to DRAIN.
    - If only the owner still requests, keep GNT low and go to DRAIN_KEEP.
    - If nobody requests, GNT all ones and go to DRAIN.
  - DRAIN / DRAIN_KEEP:
    - Wait for bus idle (IRDY==1).
    - DRAIN -> IDLE. An arbitration in IDLE needs one more edge, which guarantees the all-ones gap.
    - DRAIN_KEEP -> GRANTED with timer = 0 (back-to-back by the same master, no gap required).
- Requests that appear or disappear during BUSY have no effect until the end-of-FRAME edge.
- REQ bits with index >= NUM_MASTERS do not exist.
- Reset asserted mid-transaction: GNT goes to all ones immediately (asynchronously); the arbiter restarts at IDLE with master 0 first.
- owner holds its last value while in IDLE.

Test Plan:
- Reset, then REQ=3'b110 -> one posedge later GNT=3'b110, owner=0. FRAME low 2 cycles later -> bus_busy=1. FRAME high then IRDY high -> GNT=3'b111, bus_busy=0.
- REQ=3'b000 held, each master runs a 1-data-phase transaction when granted -> grant order 0,1,2,0. Between owners GNT=3'b111 for at least 1 cycle. GNT never has two zero bits.
- REQ=3'b101 (master 1 only), FRAME never asserted -> GNT=3'b101 for exactly 16 cycles, then GNT=3'b111 with timeout_pulse=1 for 1 cycle. With REQ=3'b100 next, master 0 is granted before master 1.
- Master 2 granted, deasserts REQ before driving FRAME -> GNT=3'b111 on the next edge; no timeout_pulse.
- Master 0 alone keeps REQ low across 3 transactions -> GNT[0] stays low continuously through DRAIN_KEEP; owner stays 0.
- rst pulsed high while bus_busy=1 and GNT=3'b011 -> GNT=3'b111 immediately. After release with REQ=3'b000, the first grant goes to master 0.
